// File: rtl/mod_counter_prog.sv
// Programmable modulo-M up/down counter with load, one-shot stop, registered
// terminal-count pulse and a saturating wrap counter.
module mod_counter_prog #(
  parameter int WIDTH      = 8,
  parameter int WRAP_WIDTH = 8
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Start_Stopb_In,
  input  logic                  Up_Downb_In,
  input  logic                  One_Shot_In,
  input  logic                  Load_In,
  input  logic [WIDTH-1:0]      Load_Value_In,
  input  logic [WIDTH-1:0]      MOD_Value_In,
  output logic [WIDTH-1:0]      Count_Out,
  output logic                  Terminal_Count_Out,
  output logic [WRAP_WIDTH-1:0] Wrap_Count_Out,
  output logic                  Done_Out,
  output logic                  Busy_Out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [WIDTH-1:0]      ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WRAP_WIDTH-1:0] WRAP_ONE = {{(WRAP_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WRAP_WIDTH-1:0] WRAP_MAX = {WRAP_WIDTH{1'b1}};

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic [WIDTH-1:0]      mS_q, mS_d;
  logic                  osS_q, osS_d;
  logic                  tc_q, tc_d;
  logic [WRAP_WIDTH-1:0] wrap_q, wrap_d;

  logic [WIDTH-1:0]      stepMax;
  logic [WIDTH-1:0]      newMax;
  logic                  termEvent;

  // M-1 falls out of plain subtraction, so a modulus of 0 yields all-ones (2^WIDTH).
  // In IDLE the shadow is being refreshed on this same edge, so the live input applies.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mS_d      = mS_q;
    osS_d     = osS_q;
    tc_d      = 1'b0;
    wrap_d    = wrap_q;
    termEvent = 1'b0;
    stepMax   = ((state_q == IDLE) ? MOD_Value_In : mS_q) - ONE;
    newMax    = MOD_Value_In - ONE;

    if (Load_In) begin
      mS_d    = MOD_Value_In;
      osS_d   = One_Shot_In;
      count_d = (Load_Value_In > newMax) ? newMax : Load_Value_In;
      wrap_d  = '0;
      state_d = Start_Stopb_In ? RUN : IDLE;
    end else begin
      if (state_q == IDLE) begin
        mS_d  = MOD_Value_In;
        osS_d = One_Shot_In;
      end

      if (Start_Stopb_In && (state_q != DONE)) begin
        state_d = RUN;
        if (Up_Downb_In) begin
          if (count_q >= stepMax) begin
            count_d   = '0;
            termEvent = 1'b1;
          end else begin
            count_d = count_q + ONE;
          end
        end else begin
          if (count_q == '0) begin
            count_d   = newMax;
            termEvent = 1'b1;
          end else if (count_q > stepMax) begin
            count_d = stepMax;
          end else begin
            count_d = count_q - ONE;
          end
        end
      end else if (!Start_Stopb_In) begin
        state_d = IDLE;
      end

      // The one-shot decision uses the shadow value from before this edge's capture.
      if (termEvent) begin
        tc_d   = 1'b1;
        wrap_d = (wrap_q == WRAP_MAX) ? wrap_q : wrap_q + WRAP_ONE;
        mS_d   = MOD_Value_In;
        osS_d  = One_Shot_In;
        if (osS_q) begin
          state_d = DONE;
        end
      end
    end
  end

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state_q <= IDLE;
      count_q <= '0;
      mS_q    <= MOD_Value_In;
      osS_q   <= One_Shot_In;
      tc_q    <= 1'b0;
      wrap_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mS_q    <= mS_d;
      osS_q   <= osS_d;
      tc_q    <= tc_d;
      wrap_q  <= wrap_d;
    end
  end

  assign Count_Out          = count_q;
  assign Terminal_Count_Out = tc_q;
  assign Wrap_Count_Out     = wrap_q;
  assign Done_Out           = (state_q == DONE);
  assign Busy_Out           = (state_q == RUN);

endmodule

// File: tb/tb_mod_counter_prog.sv
// Table-driven directed bench for mod_counter_prog at WIDTH=4, WRAP_WIDTH=2.
module tb_mod_counter_prog;

  typedef struct {
    string      tag;
    logic       rst, start, up, os, load;
    logic [3:0] ldv, mod;
    logic [3:0] eCount;
    logic       eTc;
    logic [1:0] eWrap;
    logic       eDone, eBusy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, start, up, os, load;
  logic [3:0] ldv, mod;
  logic [3:0] count;
  logic       tc, done, busy;
  logic [1:0] wrap;

  int compared   = 0;
  int mismatched = 0;

  vec_t vecs[$];

  always #5 clk = ~clk;

  mod_counter_prog #(.WIDTH(4), .WRAP_WIDTH(2)) dut (
    .Clk_In             (clk),
    .Reset_In           (rst),
    .Start_Stopb_In     (start),
    .Up_Downb_In        (up),
    .One_Shot_In        (os),
    .Load_In            (load),
    .Load_Value_In      (ldv),
    .MOD_Value_In       (mod),
    .Count_Out          (count),
    .Terminal_Count_Out (tc),
    .Wrap_Count_Out     (wrap),
    .Done_Out           (done),
    .Busy_Out           (busy)
  );

  function automatic void add(string tag, logic r, logic s, logic u, logic o, logic l,
                              logic [3:0] lv, logic [3:0] m, logic [3:0] ec, logic et,
                              logic [1:0] ew, logic ed, logic eb);
    vec_t v;
    v.tag = tag; v.rst = r; v.start = s; v.up = u; v.os = o; v.load = l;
    v.ldv = lv; v.mod = m; v.eCount = ec; v.eTc = et; v.eWrap = ew;
    v.eDone = ed; v.eBusy = eb;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst = v.rst; start = v.start; up = v.up; os = v.os; load = v.load;
    ldv = v.ldv; mod = v.mod;
    @(posedge clk);
    #1;
  endtask

  task automatic checkField(input string tag, input string field, input logic [3:0] act,
                            input logic [3:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s.%s: got %0d, expected %0d", tag, field, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v);
    checkField(v.tag, "count", count, v.eCount);
    checkField(v.tag, "tc", {3'b0, tc}, {3'b0, v.eTc});
    checkField(v.tag, "wrap", {2'b0, wrap}, {2'b0, v.eWrap});
    checkField(v.tag, "done", {3'b0, done}, {3'b0, v.eDone});
    checkField(v.tag, "busy", {3'b0, busy}, {3'b0, v.eBusy});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; up = 1'b1; os = 1'b0; load = 1'b0;
    ldv = 4'd0; mod = 4'd10;

    // Up count M=10, 25 cycles: wraps after cycles 10 and 20.
    add("t1_rst", 1, 0, 1, 0, 0, 0, 10, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 25; k++)
      add("t1_up", 0, 1, 1, 0, 0, 0, 10, 4'(k % 10), (k % 10) == 0, 2'(k / 10), 0, 1);

    // Down count M=6 after loading 3.
    add("t2_rst", 1, 0, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0);
    add("t2_ld",  0, 0, 0, 0, 1, 3, 6, 3, 0, 0, 0, 0);
    add("t2_dn",  0, 1, 0, 0, 0, 0, 6, 2, 0, 0, 0, 1);
    add("t2_dn",  0, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 1);
    add("t2_dn",  0, 1, 0, 0, 0, 0, 6, 0, 0, 0, 0, 1);
    add("t2_wr",  0, 1, 0, 0, 0, 0, 6, 5, 1, 1, 0, 1);
    add("t2_dn",  0, 1, 0, 0, 0, 0, 6, 4, 0, 1, 0, 1);
    add("t2_dn",  0, 1, 0, 0, 0, 0, 6, 3, 0, 1, 0, 1);
    add("t2_dn",  0, 1, 0, 0, 0, 0, 6, 2, 0, 1, 0, 1);
    add("t2_dn",  0, 1, 0, 0, 0, 0, 6, 1, 0, 1, 0, 1);

    // One-shot M=4: stop in DONE, load out of DONE, release via Start=0.
    add("t3_rst", 1, 0, 1, 1, 0, 0, 4, 0, 0, 0, 0, 0);
    add("t3_up",  0, 1, 1, 1, 0, 0, 4, 1, 0, 0, 0, 1);
    add("t3_up",  0, 1, 1, 1, 0, 0, 4, 2, 0, 0, 0, 1);
    add("t3_up",  0, 1, 1, 1, 0, 0, 4, 3, 0, 0, 0, 1);
    add("t3_tc",  0, 1, 1, 1, 0, 0, 4, 0, 1, 1, 1, 0);
    add("t3_hld", 0, 1, 1, 1, 0, 0, 4, 0, 0, 1, 1, 0);
    add("t3_hld", 0, 1, 1, 1, 0, 0, 4, 0, 0, 1, 1, 0);
    add("t3_ld",  0, 1, 1, 1, 1, 2, 4, 2, 0, 0, 0, 1);
    add("t3_up",  0, 1, 1, 1, 0, 0, 4, 3, 0, 0, 0, 1);
    add("t3_tc2", 0, 1, 1, 1, 0, 0, 4, 0, 1, 1, 1, 0);
    add("t3_rel", 0, 0, 1, 1, 0, 0, 4, 0, 0, 1, 0, 0);
    add("t3_res", 0, 1, 1, 1, 0, 0, 4, 1, 0, 1, 0, 1);

    // Modulus change mid-count takes effect at the next wrap.
    add("t4_rst", 1, 0, 1, 0, 0, 0, 10, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 7; k++)
      add("t4_up", 0, 1, 1, 0, 0, 0, 10, 4'(k), 0, 0, 0, 1);
    add("t4_old", 0, 1, 1, 0, 0, 0, 5, 8, 0, 0, 0, 1);
    add("t4_old", 0, 1, 1, 0, 0, 0, 5, 9, 0, 0, 0, 1);
    add("t4_wr1", 0, 1, 1, 0, 0, 0, 5, 0, 1, 1, 0, 1);
    for (int k = 1; k <= 4; k++)
      add("t4_new", 0, 1, 1, 0, 0, 0, 5, 4'(k), 0, 1, 0, 1);
    add("t4_wr2", 0, 1, 1, 0, 0, 0, 5, 0, 1, 2, 0, 1);
    add("t4_ldcl", 0, 0, 1, 0, 1, 12, 5, 4, 0, 0, 0, 0);

    // M=1: every step is terminal; wrap counter saturates at 3.
    add("t5_rst", 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add("t5_m1",  0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 0, 1);
    add("t5_m1",  0, 1, 1, 0, 0, 0, 1, 0, 1, 2, 0, 1);
    add("t5_m1",  0, 1, 1, 0, 0, 0, 1, 0, 1, 3, 0, 1);
    add("t5_sat", 0, 1, 1, 0, 0, 0, 1, 0, 1, 3, 0, 1);
    add("t5_sat", 0, 1, 1, 0, 0, 0, 1, 0, 1, 3, 0, 1);
    add("t5_sat", 0, 1, 1, 0, 0, 0, 1, 0, 1, 3, 0, 1);

    // Reset beats load mid-run; then M=0 gives natural binary wrap.
    add("t6_rst", 1, 0, 1, 0, 0, 0, 10, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++)
      add("t6_up", 0, 1, 1, 0, 0, 0, 10, 4'(k), 0, 0, 0, 1);
    add("t6_rvl", 1, 1, 1, 0, 1, 7, 0, 0, 0, 0, 0, 0);
    add("t6_ld",  0, 0, 1, 0, 1, 14, 0, 14, 0, 0, 0, 0);
    add("t6_up",  0, 1, 1, 0, 0, 0, 0, 15, 0, 0, 0, 1);
    add("t6_wr",  0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    add("t6_up",  0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1);

    // Out-of-range count stepping down snaps to M-1; Start=0 holds in IDLE.
    add("t7_rst", 1, 0, 1, 0, 0, 0, 10, 0, 0, 0, 0, 0);
    add("t7_ld",  0, 0, 1, 0, 1, 9, 10, 9, 0, 0, 0, 0);
    add("t7_oor", 0, 1, 0, 0, 0, 0, 5, 4, 0, 0, 0, 1);
    add("t7_dn",  0, 1, 0, 0, 0, 0, 5, 3, 0, 0, 0, 1);
    add("t7_hld", 0, 0, 0, 0, 0, 0, 5, 3, 0, 0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    // Direction reversal mid-count with no flush.
    vecs.delete();
    add("rv_rst", 1, 0, 1, 0, 0, 0, 10, 0, 0, 0, 0, 0);
    add("rv_up",  0, 1, 1, 0, 0, 0, 10, 1, 0, 0, 0, 1);
    add("rv_up",  0, 1, 1, 0, 0, 0, 10, 2, 0, 0, 0, 1);
    add("rv_dn",  0, 1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 1);
    add("rv_dn",  0, 1, 0, 0, 0, 0, 10, 0, 0, 0, 0, 1);
    add("rv_dwr", 0, 1, 0, 0, 0, 0, 10, 9, 1, 1, 0, 1);
    add("rv_uwr", 0, 1, 1, 0, 0, 0, 10, 0, 1, 2, 0, 1);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
